// File: rtl/deserializador_8_if.sv
// Byte-in / word-out bus between the PHY-side byte stream and the MAC-side packer.
// The master drives bytes and width selection; the slave (packer) returns assembled words.
interface deserializador_8_if #(
  parameter int BYTE_W = 8,
  parameter int WORD_W = 32
);
  logic [1:0]        PCLK;
  logic              MODO;
  logic [BYTE_W-1:0] in_8;
  logic              valid_in;
  logic              sync;
  logic [WORD_W-1:0] out_32;
  logic              valid_out;
  logic              busy;

  modport master (
    output PCLK, MODO, in_8, valid_in, sync,
    input  out_32, valid_out, busy
  );

  modport slave (
    input  PCLK, MODO, in_8, valid_in, sync,
    output out_32, valid_out, busy
  );
endinterface

// File: rtl/deserializador_8.sv
// Receive-side byte packer: assembles 8-bit PHY bytes into 32/16/8-bit MAC words,
// first byte in the most significant used byte, unused upper bytes zero.

// One byte slot of the accumulator: load the incoming byte, clear on word start, else hold.
module deser_slot #(
  parameter int BYTE_W = 8
) (
  input  logic [BYTE_W-1:0] cur_i,
  input  logic [BYTE_W-1:0] byte_i,
  input  logic              we_i,
  input  logic              clr_i,
  output logic [BYTE_W-1:0] nxt_o
);
  assign nxt_o = we_i ? byte_i : (clr_i ? '0 : cur_i);
endmodule

module deserializador_8 #(
  parameter int BYTE_W = 8,
  parameter int WORD_W = 32
) (
  input  logic                 clk,
  input  logic                 reset_L,
  deserializador_8_if.slave    bus
);
  localparam int NB = WORD_W / BYTE_W;
  localparam int CW = 3;

  typedef enum logic {IDLE, COLLECT} state_e;

  state_e                       state_q;
  logic [CW-1:0]                cnt_q;
  logic [CW-1:0]                n_q;
  logic [NB-1:0][BYTE_W-1:0]    acc_q;
  logic [NB-1:0][BYTE_W-1:0]    acc_d;
  logic [NB-1:0][BYTE_W-1:0]    out_q;
  logic                         vld_q;
  logic                         busy_q;

  logic [CW-1:0] eff_n;
  logic [CW-1:0] n_use;
  logic [CW-1:0] k;
  logic [CW-1:0] pos;
  logic          start;
  logic          accept;
  logic          done;

  // A byte opens a new word when idle or when sync realigns; width is then sampled
  // from PCLK/MODO, otherwise the width latched at word start is used.
  always_comb begin
    eff_n = '0;
    if (bus.MODO) eff_n = CW'(NB);
    else begin
      case (bus.PCLK)
        2'b00:   eff_n = CW'(NB);
        2'b01:   eff_n = CW'(2);
        2'b10:   eff_n = CW'(1);
        default: eff_n = '0;
      endcase
    end
    start  = bus.sync || (state_q == IDLE);
    n_use  = start ? eff_n : n_q;
    k      = start ? '0 : cnt_q;
    accept = bus.valid_in && (n_use != '0);
    pos    = n_use - CW'(1) - k;
    done   = accept && ((k + CW'(1)) == n_use);
  end

  for (genvar i = 0; i < NB; i++) begin : g_slot
    deser_slot #(.BYTE_W(BYTE_W)) u_slot (
      .cur_i  (acc_q[i]),
      .byte_i (bus.in_8),
      .we_i   (accept && (pos == CW'(i))),
      .clr_i  (start),
      .nxt_o  (acc_d[i])
    );
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      n_q     <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      vld_q <= 1'b0;
      if (accept) begin
        if (done) begin
          out_q   <= acc_d;
          vld_q   <= 1'b1;
          acc_q   <= '0;
          cnt_q   <= '0;
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end else begin
          acc_q   <= acc_d;
          cnt_q   <= k + CW'(1);
          n_q     <= n_use;
          state_q <= COLLECT;
          busy_q  <= 1'b1;
        end
      end else if (bus.sync) begin
        // Realign with no usable byte: drop the partial word entirely.
        acc_q   <= '0;
        cnt_q   <= '0;
        state_q <= IDLE;
        busy_q  <= 1'b0;
      end
    end
  end

  assign bus.out_32    = out_q;
  assign bus.valid_out = vld_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_deserializador_8.sv
// Cycle-level directed bench for deserializador_8: each vector is one clock of inputs
// with the outputs expected just after that edge.
module tb_deserializador_8;
  logic clk;
  logic reset_L;
  int   checks;
  int   errors;

  deserializador_8_if bus ();

  deserializador_8 dut (
    .clk     (clk),
    .reset_L (reset_L),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        vi;
    logic        sy;
    logic [1:0]  pclk;
    logic        modo;
    logic [7:0]  d;
    logic        ev;
    logic [31:0] eo;
    logic        eb;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic vi, logic sy, logic [1:0] pclk, logic modo,
                              logic [7:0] d, logic ev, logic [31:0] eo, logic eb);
    vec_t v;
    v.vi = vi; v.sy = sy; v.pclk = pclk; v.modo = modo; v.d = d;
    v.ev = ev; v.eo = eo; v.eb = eb;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(string tag, logic ev, logic [31:0] eo, logic eb);
    chk({tag, ".valid_out"}, 32'(bus.valid_out), 32'(ev));
    chk({tag, ".out_32"},    bus.out_32,         eo);
    chk({tag, ".busy"},      32'(bus.busy),      32'(eb));
  endtask

  task automatic step(vec_t v, string tag);
    @(negedge clk);
    bus.valid_in = v.vi;
    bus.sync     = v.sy;
    bus.PCLK     = v.pclk;
    bus.MODO     = v.modo;
    bus.in_8     = v.d;
    @(posedge clk);
    #1;
    chk_all(tag, v.ev, v.eo, v.eb);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset_L      = 1'b0;
    bus.valid_in = 1'b0;
    bus.sync     = 1'b0;
    bus.PCLK     = 2'b00;
    bus.MODO     = 1'b0;
    bus.in_8     = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    reset_L = 1'b1;

    // 32b word
    vecs.push_back(mk(1, 0, 2'b00, 0, 8'hAA, 0, 32'h0, 1));
    vecs.push_back(mk(1, 0, 2'b00, 0, 8'hBB, 0, 32'h0, 1));
    vecs.push_back(mk(1, 0, 2'b00, 0, 8'hCC, 0, 32'h0, 1));
    vecs.push_back(mk(1, 0, 2'b00, 0, 8'hDD, 1, 32'hAABBCCDD, 0));
    vecs.push_back(mk(0, 0, 2'b00, 0, 8'h00, 0, 32'hAABBCCDD, 0));
    // 16b then 8b, back-to-back 8b words
    vecs.push_back(mk(1, 0, 2'b01, 0, 8'h12, 0, 32'hAABBCCDD, 1));
    vecs.push_back(mk(1, 0, 2'b01, 0, 8'h34, 1, 32'h00001234, 0));
    vecs.push_back(mk(1, 0, 2'b10, 0, 8'h5A, 1, 32'h0000005A, 0));
    vecs.push_back(mk(1, 0, 2'b10, 0, 8'h01, 1, 32'h00000001, 0));
    vecs.push_back(mk(1, 0, 2'b10, 0, 8'h02, 1, 32'h00000002, 0));
    vecs.push_back(mk(0, 0, 2'b10, 0, 8'h00, 0, 32'h00000002, 0));
    // MODO forces 32b; PCLK=11 idle drops bytes
    vecs.push_back(mk(1, 0, 2'b10, 1, 8'h11, 0, 32'h00000002, 1));
    vecs.push_back(mk(1, 0, 2'b10, 1, 8'h22, 0, 32'h00000002, 1));
    vecs.push_back(mk(1, 0, 2'b10, 1, 8'h33, 0, 32'h00000002, 1));
    vecs.push_back(mk(1, 0, 2'b10, 1, 8'h44, 1, 32'h11223344, 0));
    vecs.push_back(mk(1, 0, 2'b11, 0, 8'h55, 0, 32'h11223344, 0));
    vecs.push_back(mk(1, 0, 2'b11, 0, 8'h66, 0, 32'h11223344, 0));
    // PCLK change mid-word is ignored
    vecs.push_back(mk(1, 0, 2'b00, 0, 8'hA1, 0, 32'h11223344, 1));
    vecs.push_back(mk(1, 0, 2'b00, 0, 8'hB2, 0, 32'h11223344, 1));
    vecs.push_back(mk(1, 0, 2'b10, 0, 8'hC3, 0, 32'h11223344, 1));
    vecs.push_back(mk(1, 0, 2'b10, 0, 8'hD4, 1, 32'hA1B2C3D4, 0));
    // Gaps of 3 idle cycles between bytes
    for (int b = 1; b <= 4; b++) begin
      vecs.push_back(mk(1, 0, 2'b00, 0, 8'(b), (b == 4), (b == 4) ? 32'h01020304 : 32'hA1B2C3D4,
                        (b != 4)));
      if (b != 4)
        for (int g = 0; g < 3; g++)
          vecs.push_back(mk(0, 0, 2'b00, 0, 8'hEE, 0, 32'hA1B2C3D4, 1));
    end
    // sync with a byte restarts the word at byte 0
    vecs.push_back(mk(1, 0, 2'b00, 0, 8'h9A, 0, 32'h01020304, 1));
    vecs.push_back(mk(1, 0, 2'b00, 0, 8'h9B, 0, 32'h01020304, 1));
    vecs.push_back(mk(1, 1, 2'b00, 0, 8'h11, 0, 32'h01020304, 1));
    vecs.push_back(mk(1, 0, 2'b00, 0, 8'h22, 0, 32'h01020304, 1));
    vecs.push_back(mk(1, 0, 2'b00, 0, 8'h33, 0, 32'h01020304, 1));
    vecs.push_back(mk(1, 0, 2'b00, 0, 8'h44, 1, 32'h11223344, 0));
    // sync without a byte clears the partial word
    vecs.push_back(mk(1, 0, 2'b01, 0, 8'h77, 0, 32'h11223344, 1));
    vecs.push_back(mk(0, 1, 2'b01, 0, 8'h00, 0, 32'h11223344, 0));
    vecs.push_back(mk(1, 0, 2'b01, 0, 8'h88, 0, 32'h11223344, 1));
    vecs.push_back(mk(1, 0, 2'b01, 0, 8'h99, 1, 32'h00008899, 0));
    // Three bytes of a word that reset will interrupt
    vecs.push_back(mk(1, 0, 2'b00, 0, 8'hE1, 0, 32'h00008899, 1));
    vecs.push_back(mk(1, 0, 2'b00, 0, 8'hE2, 0, 32'h00008899, 1));
    vecs.push_back(mk(1, 0, 2'b00, 0, 8'hE3, 0, 32'h00008899, 1));

    foreach (vecs[i]) step(vecs[i], $sformatf("vec%0d", i));

    // Asynchronous reset mid-word: outputs clear before any clock edge
    @(negedge clk);
    bus.valid_in = 1'b0;
    #2;
    reset_L = 1'b0;
    #1;
    chk_all("async_reset", 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    reset_L = 1'b1;
    step(mk(1, 0, 2'b00, 0, 8'hF1, 0, 32'h0, 1), "post_rst0");
    step(mk(1, 0, 2'b00, 0, 8'hF2, 0, 32'h0, 1), "post_rst1");
    step(mk(1, 0, 2'b00, 0, 8'hF3, 0, 32'h0, 1), "post_rst2");
    step(mk(1, 0, 2'b00, 0, 8'hF4, 1, 32'hF1F2F3F4, 0), "post_rst3");
    step(mk(0, 0, 2'b00, 0, 8'h00, 0, 32'hF1F2F3F4, 0), "post_rst4");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
